// File: rtl/clk_gen_nco_pkg.sv
// Shared constants and elaboration-time helpers for the clk_gen_nco clock generator.
// Frequency resolution of the generator is REF_FREQ_HZ / 2^ACC_W.
package clk_gen_nco_pkg;

    localparam int ACC_W_DEFAULT = 32;
    localparam int ACC_W_MIN     = 16;
    localparam int ACC_W_MAX     = 48;

    // round(f_hz / ref_hz * 2^acc_w); casting a real to an integral type rounds to nearest
    function automatic logic [63:0] calc_tuning_word(input real f_hz, input real ref_hz,
                                                     input int acc_w);
        real    scale;
        longint tw_l;
        scale = 1.0;
        for (int i = 0; i < acc_w; i++) begin
            scale = scale * 2.0;
        end
        tw_l = longint'((f_hz / ref_hz) * scale);
        return tw_l;
    endfunction

    function automatic bit check_freq_range(input real f_hz, input real ref_hz);
        return (f_hz > 0.0) && (f_hz <= (ref_hz / 2.0));
    endfunction

endpackage

// File: rtl/clk_gen_phase_acc.sv
// Phase accumulator for clk_gen_nco: acc <= acc + tw (wrapping), or 0 when cleared.
// Exposes the MSB of the value being loaded so the caller can register it in the same cycle.
module clk_gen_phase_acc
    import clk_gen_nco_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [ACC_W-1:0] tw_i,
    output logic             msb_next_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Next phase: synchronous clear has priority over accumulation
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = {ACC_W{1'b0}};
        end else begin
            acc_d = acc_q + tw_i;
        end
    end

    // Phase register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign msb_next_o = acc_d[ACC_W-1];

endmodule

// File: rtl/clk_gen_nco.sv
// Numerically-controlled clock generator: gen_clk at FREQ*FREQ_UNIT Hz from clk via a phase accumulator.
// Optional runtime tuning-word load enabled by defining CLK_GEN_NCO_PROG_EN.
module clk_gen_nco
    import clk_gen_nco_pkg::*;
#(
    parameter real FREQ        = 10.0,
    parameter real FREQ_UNIT   = 1e6,
    parameter real REF_FREQ_HZ = 1e9,
    parameter int  ACC_W       = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef CLK_GEN_NCO_PROG_EN
    input  logic             tw_load,
    input  logic [ACC_W-1:0] tw_in,
`endif
    output logic             gen_clk,
    output logic             gen_rise
);

    localparam real              F_HZ = FREQ * FREQ_UNIT;
    localparam logic [63:0]      TW64 = calc_tuning_word(F_HZ, REF_FREQ_HZ, ACC_W);
    localparam logic [ACC_W-1:0] TW   = TW64[ACC_W-1:0];

    // A tuning word that rounds to zero is legal and simply yields a constant-low output
    if (!check_freq_range(F_HZ, REF_FREQ_HZ)) begin : g_bad_freq
        $fatal(1, "clk_gen_nco: FREQ*FREQ_UNIT must be > 0 and <= REF_FREQ_HZ/2");
    end
    if ((ACC_W < ACC_W_MIN) || (ACC_W > ACC_W_MAX)) begin : g_bad_accw
        $fatal(1, "clk_gen_nco: ACC_W must be within 16..48");
    end

    logic             tw_s;
    logic [ACC_W-1:0] tw_word_s;
    logic             msb_next_s;
    logic             gen_clk_q;
    logic             gen_clk_d;
    logic             gen_rise_q;
    logic             gen_rise_d;

    assign tw_s = 1'b0;

`ifdef CLK_GEN_NCO_PROG_EN
    logic [ACC_W-1:0] tw_q;
    logic [ACC_W-1:0] tw_d;

    // A loaded word is used from the accumulation after the load edge
    always_comb begin
        tw_d = tw_q;
        if (tw_load) begin
            tw_d = tw_in;
        end else begin
            tw_d = tw_q;
        end
    end

    // Active tuning word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_q <= TW;
        end else begin
            tw_q <= tw_d;
        end
    end

    assign tw_word_s = tw_q;
`else
    assign tw_word_s = TW;
`endif

    clk_gen_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (~en),
        .tw_i       (tw_word_s),
        .msb_next_o (msb_next_s)
    );

    // Output follows the new phase MSB; disabling restarts from zero phase
    always_comb begin
        gen_clk_d  = 1'b0;
        gen_rise_d = 1'b0;
        if (en) begin
            gen_clk_d  = msb_next_s;
            gen_rise_d = msb_next_s & ~gen_clk_q;
        end else begin
            gen_clk_d  = 1'b0;
            gen_rise_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_clk_q  <= 1'b0;
            gen_rise_q <= 1'b0;
        end else begin
            gen_clk_q  <= gen_clk_d | tw_s;
            gen_rise_q <= gen_rise_d;
        end
    end

    assign gen_clk  = gen_clk_q;
    assign gen_rise = gen_rise_q;

endmodule

// File: tb/tb_clk_gen_nco.sv
// Self-checking bench for clk_gen_nco: three parameterisations (10, 93, 500 MHz from 1 GHz)
// checked every cycle against an arithmetic phase model, plus latency, reset, gap and period checks.
module tb_clk_gen_nco;

    localparam longint TW10  = 64'd42949673;
    localparam longint TW93  = 64'd399431959;
    localparam longint TW500 = 64'd2147483648;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic gc10, gr10, gc93, gr93, gc500, gr500;
    logic tw_load = 1'b0;
    logic [31:0] tw_in = 32'd0;
    logic tie0 = 1'b0;
    logic [31:0] tie_w = 32'd0;

    int     n_checks = 0;
    int     n_fail = 0;
    bit     chk_on = 1'b1;
    longint n_en = 0;

    always #5 clk = ~clk;

    clk_gen_nco u_dut10 (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef CLK_GEN_NCO_PROG_EN
        .tw_load(tw_load), .tw_in(tw_in),
`endif
        .gen_clk(gc10), .gen_rise(gr10)
    );

    clk_gen_nco #(.FREQ(93.0)) u_dut93 (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef CLK_GEN_NCO_PROG_EN
        .tw_load(tie0), .tw_in(tie_w),
`endif
        .gen_clk(gc93), .gen_rise(gr93)
    );

    clk_gen_nco #(.FREQ(500.0)) u_dut500 (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef CLK_GEN_NCO_PROG_EN
        .tw_load(tie0), .tw_in(tie_w),
`endif
        .gen_clk(gc500), .gen_rise(gr500)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Ideal square wave: high while floor(n*TW/2^31) is odd, n = enabled edges since clear
    function automatic logic exp_clk(input longint n, input longint tw);
        longint p;
        p = n * tw;
        return p[31];
    endfunction

    function automatic logic exp_rise(input longint n, input longint tw);
        return (n > 0) && exp_clk(n, tw) && !exp_clk(n - 1, tw);
    endfunction

    // Count of enabled reference edges since the last clear
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  n_en <= 0;
        else if (en) n_en <= n_en + 1;
        else         n_en <= 0;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("clk10",   gc10,  exp_clk(n_en, TW10));
            check_eq("rise10",  gr10,  exp_rise(n_en, TW10));
            check_eq("clk93",   gc93,  exp_clk(n_en, TW93));
            check_eq("rise93",  gr93,  exp_rise(n_en, TW93));
            check_eq("clk500",  gc500, exp_clk(n_en, TW500));
            check_eq("rise500", gr500, exp_rise(n_en, TW500));
        end
    end

    task automatic wait_latency(input string tag, input int exp);
        int k;
        k = 301;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (gr10) begin
                k = i;
                break;
            end
        end
        check_eq(tag, k, exp);
    endtask

    task automatic async_reset(input int dly);
        @(posedge clk);
        #(dly);
        rst_n = 1'b0;
        #1;
        check_eq("arst_clk10",  gc10,  0);
        check_eq("arst_rise10", gr10,  0);
        check_eq("arst_clk93",  gc93,  0);
        check_eq("arst_clk500", gc500, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int     cnt10, cnt93, prev10, prev93, first93, p;
        real    avg93;

        #1;
        check_eq("rst_clk",  gc10, 0);
        check_eq("rst_rise", gr10, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        en = 1'b1;
        wait_latency("lat_first", 50);
        repeat (30) @(negedge clk);
        check_eq("pre_rst_high", gc10, 1);
        async_reset(2);
        wait_latency("lat_after_rst", 50);

        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_eq("gap_low", gc10, 0);
        end
        en = 1'b1;
        wait_latency("lat_reenable", 50);

        for (int it = 0; it < 30; it++) begin
            en = 1'b1;
            repeat ($urandom_range(1, 300)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                async_reset($urandom_range(1, 4));
            end else begin
                en = 1'b0;
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end
        end

        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        cnt10 = 0; cnt93 = 0; prev10 = -1; prev93 = -1; first93 = 0;
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            @(negedge clk);
            if (gr10) begin
                cnt10++;
                if (prev10 >= 0) begin
                    p = cyc - prev10;
                    check_eq("period10_in_99_101", (p >= 99 && p <= 101), 1);
                end
                prev10 = cyc;
            end
            if (gr93) begin
                cnt93++;
                if (prev93 >= 0) begin
                    p = cyc - prev93;
                    check_eq("period93_in_10_11", (p == 10 || p == 11), 1);
                end else begin
                    first93 = cyc;
                end
                prev93 = cyc;
            end
        end
        check_eq("count10_200pm1", (cnt10 >= 199 && cnt10 <= 201), 1);
        avg93 = real'(prev93 - first93) / real'(cnt93 - 1);
        check_eq("avg93_10p7527", (avg93 > 10.7517 && avg93 < 10.7537), 1);

`ifdef CLK_GEN_NCO_PROG_EN
        chk_on = 1'b0;
        tw_in = 32'd429496729;
        tw_load = 1'b1;
        @(negedge clk);
        tw_load = 1'b0;
        prev10 = -1;
        cnt10 = 0;
        for (int cyc = 1; cyc <= 400 && cnt10 < 3; cyc++) begin
            @(negedge clk);
            if (gr10) begin
                cnt10++;
                if (cnt10 == 3) check_eq("prog_period10", cyc - prev10, 10);
                prev10 = cyc;
            end
        end
        check_eq("prog_rises_seen", cnt10, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
